irq_sched_ctrl: RTL and testbench
=================================

Name: irq_sched_ctrl

Overview:
- Interrupt scheduler in front of the jump control block.
- Captures four edge-triggered interrupt sources and masks them.
- Picks one winner by fixed priority and presents its 8-bit vector to the jump control block with a req/ack handshake.
- Tracks the in-service source until return-from-interrupt; no nesting.

Parameters:
- VEC_BASE, 8'hF0, vector address of source 0.
- VEC_STRIDE, 8'h04, vector spacing between sources.
- MASK_RST, 4'h0, mask value after reset (1 = masked).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  4  raw interrupt lines, rising-edge sensitive.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  4  new mask value.
- reti  in  1  one-cycle pulse: return-from-interrupt decoded.
- irq_ack  in  1  jump control has taken the vector (pc redirected).
- irq_req  out  1  interrupt pending for the jump control block.
- vector  out  8  jump target for the winning source.
- pending  out  4  latched, not yet serviced edges.
- in_service  out  4  one-hot source being serviced (0 = none).
- mask  out  4  current mask register.

Behaviour:
- Reset (async): irq_req=0, vector=VEC_BASE, pending=0, in_service=0, mask=MASK_RST, edge history=0, FSM=IDLE.
- Edge detect: a registered copy of irq_in is held.
  - Bit i is set in pending at the edge where irq_in[i]=1 and prev[i]=0.
  - A level held high sets pending only once.
- Pending is set regardless of mask; a masked pending bit waits until it is unmasked.
- Mask: on mask_we, mask<=mask_wdata at the same edge. Mask does not affect a request already in REQ.
- Priority: lowest index wins among (pending & ~mask).
- Vector: VEC_BASE + id*VEC_STRIDE, truncated to 8 bits, wrap-around allowed. It is registered and stable while irq_req=1.
- FSM states:
  - IDLE:
    - irq_req=0.
    - If (pending & ~mask)!=0: latch winner id and vector, go REQ, irq_req=1 from the next cycle.
  - REQ:
    - Hold irq_req=1 and vector.
    - On irq_ack: clear pending[id], set in_service[id], irq_req=0, go SERVICE.
  - SERVICE:
    - Ignore new requests; they keep accumulating in pending.
    - On reti: in_service<=0, go IDLE.
- Latency: irq_in rise sampled at edge k -> pending set after k -> irq_req=1 after k+1. Earliest re-request after reti is the cycle after the return to IDLE.
- Simultaneous events:
  - New edge on pending[id] in the same cycle as its ack-clear: set wins and the bit stays 1.
  - reti outside SERVICE is ignored.
  - irq_ack outside REQ is ignored.
  - mask_we with irq_ack: both take effect.
- Reset mid-operation: returns to IDLE immediately and drops irq_req asynchronously. Pending edges are lost.

Optional Feature:
- Macro IRQ_SCHED_ROUND_ROBIN_EN.
- When defined:
  - Priority rotates: search starts at (last_served+1) mod 4.
  - last_served is updated on irq_ack and resets to 3, so the first search starts at 0.
- When undefined: fixed priority, source 0 highest; last_served logic is absent.

Test Plan:
- Reset, then pulse irq_in=4'b0100 -> pending=4'b0100, then irq_req=1 with vector=8'hF8 one cycle later; irq_ack -> irq_req=0, in_service=4'b0100, pending=0.
- irq_in=4'b1010 in the same cycle -> vector=8'hF4 (source 1) first; after ack+reti -> vector=8'hFC (source 3).
- mask_we with mask_wdata=4'b0001, then irq_in[0] rises -> pending[0]=1, irq_req stays 0; write mask 0 -> irq_req=1, vector=8'hF0.
- In SERVICE, raise irq_in[2] -> pending[2]=1, no irq_req until reti; reti -> irq_req=1 one cycle after returning to IDLE.
- Assert reset while irq_req=1 -> irq_req=0, pending=0, in_service=0 without waiting for a clk edge.
- With IRQ_SCHED_ROUND_ROBIN_EN, keep pending=4'b0011 re-armed -> served order 0,1,0,1; without the macro -> 0,0,0.

Source files
------------

// File: rtl/irq_sched_ctrl.sv
// Interrupt scheduler: edge capture, masking, priority pick and req/ack to jump control.
// Optional rotating priority when IRQ_SCHED_ROUND_ROBIN_EN is defined.
module irq_sched_ctrl #(
  parameter logic [7:0] VEC_BASE   = 8'hF0,
  parameter logic [7:0] VEC_STRIDE = 8'h04,
  parameter logic [3:0] MASK_RST   = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic       reti,
  input  logic       irq_ack,
  output logic       irq_req,
  output logic [7:0] vector,
  output logic [3:0] pending,
  output logic [3:0] in_service,
  output logic [3:0] mask
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state, state_n;
  logic [3:0] prev_irq;
  logic [3:0] rise, eligible, pend_clr, pending_n, in_service_n;
  logic [1:0] win_id, win_id_n, pick, search_start;
  logic [7:0] vector_n;

  // Scan from the start index upward (mod 4); descending loop so the nearest hit wins.
  function automatic logic [1:0] pick_fn(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    pick_fn = start;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = start + 2'(k - 1);
      if (req[idx]) pick_fn = idx;
    end
  endfunction

`ifdef IRQ_SCHED_ROUND_ROBIN_EN
  logic [1:0] last_served;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        last_served <= 2'd3;
    else if (state == REQ && irq_ack) last_served <= win_id;
  end

  assign search_start = last_served + 2'd1;
`else
  assign search_start = 2'd0;
`endif

  assign rise      = irq_in & ~prev_irq;
  assign eligible  = pending & ~mask;
  assign pick      = pick_fn(eligible, search_start);
  // Set wins over the ack-clear for the same bit.
  assign pending_n = (pending & ~pend_clr) | rise;

  always_comb begin
    state_n      = state;
    win_id_n     = win_id;
    vector_n     = vector;
    pend_clr     = '0;
    in_service_n = in_service;
    irq_req      = (state == REQ);
    case (state)
      IDLE: begin
        if (|eligible) begin
          win_id_n = pick;
          vector_n = VEC_BASE + {6'd0, pick} * VEC_STRIDE;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          pend_clr     = 4'b0001 << win_id;
          in_service_n = 4'b0001 << win_id;
          state_n      = SERVICE;
        end
      end
      SERVICE: begin
        if (reti) begin
          in_service_n = '0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev_irq   <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= MASK_RST;
      win_id     <= 2'd0;
      vector     <= VEC_BASE;
    end else begin
      state      <= state_n;
      prev_irq   <= irq_in;
      pending    <= pending_n;
      in_service <= in_service_n;
      win_id     <= win_id_n;
      vector     <= vector_n;
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_irq_sched_ctrl.sv
// Bench for irq_sched_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_irq_sched_ctrl;

  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  localparam int VB = 'hF0, VS = 'h04;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in, mask_wdata;
  logic       mask_we, reti, irq_ack;
  logic       irq_req;
  logic [7:0] vector;
  logic [3:0] pending, in_service, mask;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int         m_mode, m_id, m_last;
  logic [3:0] m_pend, m_mask, m_insvc, m_prev;
  logic [7:0] m_vec;

  irq_sched_ctrl #(.VEC_BASE(8'hF0), .VEC_STRIDE(8'h04), .MASK_RST(4'h0)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .reti(reti), .irq_ack(irq_ack), .irq_req(irq_req), .vector(vector),
    .pending(pending), .in_service(in_service), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_model(input logic [3:0] elig, input int last);
    int start;
`ifdef IRQ_SCHED_ROUND_ROBIN_EN
    start = (last + 1) % 4;
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++)
      if (elig[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_id = 0; m_last = 3;
    m_pend = '0; m_mask = 4'h0; m_insvc = '0; m_prev = '0; m_vec = 8'hF0;
  endtask

  task automatic model_step();
    logic [3:0] clr;
    int w;
    clr = '0;
    if (m_mode == M_IDLE) begin
      w = pick_model(m_pend & ~m_mask, m_last);
      if (w >= 0) begin
        m_id   = w;
        m_vec  = 8'((VB + w * VS) % 256);
        m_mode = M_REQ;
      end
    end else if (m_mode == M_REQ) begin
      if (irq_ack) begin
        clr[m_id] = 1'b1;
        m_insvc   = '0;
        m_insvc[m_id] = 1'b1;
        m_last    = m_id;
        m_mode    = M_SVC;
      end
    end else if (reti) begin
      m_insvc = '0;
      m_mode  = M_IDLE;
    end
    m_pend = (m_pend & ~clr) | (irq_in & ~m_prev);
    if (mask_we) m_mask = mask_wdata;
    m_prev = irq_in;
  endtask

  task automatic check_all();
    check("irq_req", {31'd0, irq_req}, {31'd0, m_mode == M_REQ});
    check("vector", {24'd0, vector}, {24'd0, m_vec});
    check("pending", {28'd0, pending}, {28'd0, m_pend});
    check("in_service", {28'd0, in_service}, {28'd0, m_insvc});
    check("mask", {28'd0, mask}, {28'd0, m_mask});
  endtask

  task automatic cycle(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                       input logic rt, input logic ak);
    @(negedge clk);
    irq_in = irq; mask_we = we; mask_wdata = wd; reti = rt; irq_ack = ak;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_irq_req", {31'd0, irq_req}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_in_service", {28'd0, in_service}, 32'd0);
    model_reset();
    @(negedge clk);
    irq_in = '0; mask_we = 0; reti = 0; irq_ack = 0;
    m_prev = '0;
    #1 reset = 1'b0;
  endtask

  int served;
  int exp_order[4];

  initial begin
    reset = 1'b1; irq_in = '0; mask_we = 0; mask_wdata = '0; reti = 0; irq_ack = 0;
    model_reset();
    #12;
    check_all();
    check("reset_vector", {24'd0, vector}, 32'hF0);
    @(negedge clk) reset = 1'b0;

    // Single source 2
    cycle(4'b0100, 0, 0, 0, 0);
    check("t1_pending", {28'd0, pending}, 32'b0100);
    check("t1_no_req_yet", {31'd0, irq_req}, 32'd0);
    cycle(4'b0100, 0, 0, 0, 0);
    check("t1_req", {31'd0, irq_req}, 32'd1);
    check("t1_vector", {24'd0, vector}, 32'hF8);
    cycle(4'b0100, 0, 0, 0, 1);
    check("t1_ack_req", {31'd0, irq_req}, 32'd0);
    check("t1_in_service", {28'd0, in_service}, 32'b0100);
    check("t1_pending_clr", {28'd0, pending}, 32'd0);
    cycle(4'b0000, 0, 0, 1, 0);

    // Two simultaneous sources
    cycle(4'b1010, 0, 0, 0, 0);
    cycle(4'b1010, 0, 0, 0, 0);
    check("t2_vec_src1", {24'd0, vector}, 32'hF4);
    cycle(4'b1010, 0, 0, 0, 1);
    cycle(4'b0000, 0, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t2_vec_src3", {24'd0, vector}, 32'hFC);
    check("t2_req3", {31'd0, irq_req}, 32'd1);
    cycle(4'b0000, 0, 0, 0, 1);
    cycle(4'b0000, 0, 0, 1, 0);

    // Masked pending waits for unmask
    cycle(4'b0000, 1, 4'b0001, 0, 0);
    cycle(4'b0001, 0, 0, 0, 0);
    check("t3_pending0", {28'd0, pending}, 32'b0001);
    cycle(4'b0001, 0, 0, 0, 0);
    check("t3_masked_noreq", {31'd0, irq_req}, 32'd0);
    cycle(4'b0001, 1, 4'b0000, 0, 0);
    cycle(4'b0001, 0, 0, 0, 0);
    check("t3_unmasked_req", {31'd0, irq_req}, 32'd1);
    check("t3_vec0", {24'd0, vector}, 32'hF0);
    cycle(4'b0001, 0, 0, 0, 1);

    // New edge during service waits for reti
    cycle(4'b0101, 0, 0, 0, 0);
    check("t4_pending2", {28'd0, pending}, 32'b0100);
    cycle(4'b0101, 0, 0, 0, 0);
    check("t4_svc_noreq", {31'd0, irq_req}, 32'd0);
    cycle(4'b0101, 0, 0, 1, 0);
    check("t4_idle_noreq", {31'd0, irq_req}, 32'd0);
    cycle(4'b0101, 0, 0, 0, 0);
    check("t4_rereq", {31'd0, irq_req}, 32'd1);

    // Async reset while requesting
    async_reset();
    check_all();

    // Served order with sources 0 and 1 continually re-armed
`ifdef IRQ_SCHED_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    cycle(4'b0011, 0, 0, 0, 0);
    cycle(4'b0011, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      cycle(4'b0011, 0, 0, 0, 1);
      served = -1;
      for (int b = 0; b < 4; b++) if (in_service[b]) served = b;
      check("order", served, exp_order[r]);
      cycle(4'b0011 & ~(4'b0001 << served), 0, 0, 0, 0);
      cycle(4'b0011, 0, 0, 0, 0);
      cycle(4'b0011, 0, 0, 1, 0);
      cycle(4'b0011, 0, 0, 0, 0);
    end

    // Random traffic
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else cycle(4'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
